// File: rtl/ldst_sched.sv
// ldst_sched: sequencer/arbiter in front of the load/store traffic block.
//   Issues one-cycle load grants (self_rd_en) to NUM_LDQ load agents in
//   round-robin (mode=0) or parallel (mode=1) fashion. Outstanding loads are
//   limited by per-queue credits. Level store enables (self_wr_en) are driven
//   to NUM_STQ store agents. Completed stores are counted. The host sees an
//   init pulse, a busy level and a done level.
// Ports:
//   clk, rstn                       clock, async active-low reset
//   enable, mode                    job run level, grant mode
//   cfg_num_ld, cfg_num_st          per-queue load/store counts (sampled in INIT)
//   init, done, busy                host handshake
//   self_rd_en, self_wr_en          load grants, store enables
//   ldq_data_valid/ready            load data handshake (credit return)
//   stq_valid/ready                 store handshake (store completion)
//   perf_cycles                     RUN cycle counter
// Optional feature: define LDST_SCHED_PERF_EN to build the perf_cycles counter;
// otherwise perf_cycles is tied to zero.
module ldst_sched #(
    parameter int unsigned NUM_LDQ    = 4,
    parameter int unsigned NUM_STQ    = 1,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned MAX_OUTSTD = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 enable,
    input  logic                 mode,
    input  logic [CNT_WIDTH-1:0] cfg_num_ld,
    input  logic [CNT_WIDTH-1:0] cfg_num_st,
    output logic                 init,
    output logic                 done,
    output logic                 busy,
    output logic [NUM_LDQ-1:0]   self_rd_en,
    output logic [NUM_STQ-1:0]   self_wr_en,
    input  logic [NUM_LDQ-1:0]   ldq_data_valid,
    input  logic [NUM_LDQ-1:0]   ldq_data_ready,
    input  logic [NUM_STQ-1:0]   stq_valid,
    input  logic [NUM_STQ-1:0]   stq_ready,
    output logic [31:0]          perf_cycles
);

    localparam int unsigned CR_W = $clog2(MAX_OUTSTD + 1);
    localparam int unsigned RR_W = (NUM_LDQ > 1) ? $clog2(NUM_LDQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e state_q, state_d;

    logic [CNT_WIDTH-1:0]               cfg_ld_q, cfg_ld_d;
    logic [CNT_WIDTH-1:0]               cfg_st_q, cfg_st_d;
    logic [NUM_LDQ-1:0][CNT_WIDTH-1:0]  issued_q, issued_d;
    logic [NUM_LDQ-1:0][CR_W-1:0]       credit_q, credit_d;
    logic [NUM_STQ-1:0][CNT_WIDTH-1:0]  stored_q, stored_d;
    logic [RR_W-1:0]                    rr_q, rr_d;
    logic [NUM_LDQ-1:0]                 rd_en_q, rd_en_d;
    logic [NUM_STQ-1:0]                 wr_en_q, wr_en_d;
    logic                               init_q, init_d;
    logic                               done_q, done_d;
    logic                               busy_q, busy_d;

    logic [NUM_LDQ-1:0] ld_ret;
    logic [NUM_STQ-1:0] st_fire;
    logic [NUM_LDQ-1:0] elig;
    logic               found;
    int unsigned        pick;
    logic [RR_W-1:0]    pick_idx;
    logic               ld_all_done_c;
    logic               st_all_done_c;
    logic               any_credit_c;

    assign ld_ret  = ldq_data_valid & ldq_data_ready;
    assign st_fire = stq_valid & stq_ready;

    // Job completion and drain status, evaluated on registered counts
    always_comb begin
        ld_all_done_c = 1'b1;
        any_credit_c  = 1'b0;
        st_all_done_c = 1'b1;
        for (int unsigned i = 0; i < NUM_LDQ; i++) begin
            if (issued_q[i] != cfg_ld_q || credit_q[i] != '0) ld_all_done_c = 1'b0;
            if (credit_q[i] != '0) any_credit_c = 1'b1;
        end
        for (int unsigned j = 0; j < NUM_STQ; j++) begin
            if (stored_q[j] != cfg_st_q) st_all_done_c = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; abort has priority over completion in RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (enable && !done_q) state_d = S_INIT;
            S_INIT:  state_d = enable ? S_RUN : S_IDLE;
            S_RUN: begin
                if (!enable)                             state_d = S_DRAIN;
                else if (ld_all_done_c && st_all_done_c) state_d = S_DONE;
            end
            S_DRAIN: if (!any_credit_c) state_d = S_IDLE;
            S_DONE:  if (!enable) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Counter updates and next-cycle outputs. Grants are computed from the
    // updated counts so the registered grant never over-issues or overflows credit.
    always_comb begin
        cfg_ld_d = cfg_ld_q;
        cfg_st_d = cfg_st_q;
        issued_d = issued_q;
        credit_d = credit_q;
        stored_d = stored_q;
        rr_d     = rr_q;
        elig     = '0;
        found    = 1'b0;
        pick     = 0;
        pick_idx = '0;
        rd_en_d  = '0;
        wr_en_d  = '0;

        if (state_q == S_INIT) begin
            cfg_ld_d = cfg_num_ld;
            cfg_st_d = cfg_num_st;
            issued_d = '0;
            credit_d = '0;
            stored_d = '0;
        end else begin
            for (int unsigned i = 0; i < NUM_LDQ; i++) begin
                if (rd_en_q[i]) issued_d[i] = issued_q[i] + CNT_WIDTH'(1);
                // Grant with simultaneous return leaves the credit unchanged
                if (rd_en_q[i] && !ld_ret[i])
                    credit_d[i] = credit_q[i] + CR_W'(1);
                else if (!rd_en_q[i] && ld_ret[i] && credit_q[i] != '0)
                    credit_d[i] = credit_q[i] - CR_W'(1);
            end
            for (int unsigned j = 0; j < NUM_STQ; j++) begin
                if (state_q == S_RUN && st_fire[j] && stored_q[j] < cfg_st_q)
                    stored_d[j] = stored_q[j] + CNT_WIDTH'(1);
            end
        end

        for (int unsigned i = 0; i < NUM_LDQ; i++) begin
            elig[i] = (state_d == S_RUN) && (issued_d[i] < cfg_ld_d) &&
                      (credit_d[i] < CR_W'(MAX_OUTSTD));
        end

        if (mode) begin
            rd_en_d = elig;
        end else begin
            // Circular search for the first eligible queue starting at rr
            for (int unsigned k = 0; k < NUM_LDQ; k++) begin
                pick     = (32'(rr_q) + k) % NUM_LDQ;
                pick_idx = RR_W'(pick);
                if (!found && elig[pick_idx]) begin
                    found             = 1'b1;
                    rd_en_d[pick_idx] = 1'b1;
                    rr_d              = (pick == NUM_LDQ - 1) ? '0 : RR_W'(pick + 1);
                end
            end
        end

        for (int unsigned j = 0; j < NUM_STQ; j++) begin
            wr_en_d[j] = (state_d == S_RUN) && (stored_d[j] < cfg_st_d);
        end

        init_d = (state_d == S_INIT);
        done_d = (state_d == S_DONE);
        busy_d = (state_d == S_INIT) || (state_d == S_RUN) || (state_d == S_DRAIN);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cfg_ld_q <= '0;
            cfg_st_q <= '0;
            issued_q <= '0;
            credit_q <= '0;
            stored_q <= '0;
            rr_q     <= '0;
            rd_en_q  <= '0;
            wr_en_q  <= '0;
            init_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            cfg_ld_q <= cfg_ld_d;
            cfg_st_q <= cfg_st_d;
            issued_q <= issued_d;
            credit_q <= credit_d;
            stored_q <= stored_d;
            rr_q     <= rr_d;
            rd_en_q  <= rd_en_d;
            wr_en_q  <= wr_en_d;
            init_q   <= init_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign init       = init_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign self_rd_en = rd_en_q;
    assign self_wr_en = wr_en_q;

`ifdef LDST_SCHED_PERF_EN
    logic [31:0] perf_q, perf_d;

    // RUN cycle counter: cleared in INIT, saturating, held outside RUN
    always_comb begin
        perf_d = perf_q;
        if (state_q == S_INIT)                          perf_d = '0;
        else if (state_q == S_RUN && perf_q != '1)      perf_d = perf_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) perf_q <= '0;
        else       perf_q <= perf_d;
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_ldst_sched.sv
// Directed testbench for ldst_sched: expected grants are queued when a scenario
// is driven and popped as the DUT issues them; handshake timing checked inline.
module tb_ldst_sched;

    logic        clk;
    logic        rstn;
    logic        enable;
    logic        mode;
    logic [15:0] cfg_num_ld;
    logic [15:0] cfg_num_st;
    logic        init;
    logic        done;
    logic        busy;
    logic [3:0]  self_rd_en;
    logic [0:0]  self_wr_en;
    logic [3:0]  ldq_data_valid;
    logic [3:0]  ldq_data_ready;
    logic [0:0]  stq_valid;
    logic [0:0]  stq_ready;
    logic [31:0] perf_cycles;

    ldst_sched dut (
        .clk            (clk),
        .rstn           (rstn),
        .enable         (enable),
        .mode           (mode),
        .cfg_num_ld     (cfg_num_ld),
        .cfg_num_st     (cfg_num_st),
        .init           (init),
        .done           (done),
        .busy           (busy),
        .self_rd_en     (self_rd_en),
        .self_wr_en     (self_wr_en),
        .ldq_data_valid (ldq_data_valid),
        .ldq_data_ready (ldq_data_ready),
        .stq_valid      (stq_valid),
        .stq_ready      (stq_ready),
        .perf_cycles    (perf_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cycle    = 0;
    int first_gnt;
    int last_gnt;
    int last_ret;
    int ret_mode;          // 0 manual, 1 return 2 cycles after grant, 2 same-cycle masked
    logic [3:0] ret_mask;
    logic [3:0] d1, d2;
    logic [3:0] sb[$];     // expected grant vectors in issue order

`ifdef LDST_SCHED_PERF_EN
    localparam logic [31:0] PERF_T6 = 32'd1;
`else
    localparam logic [31:0] PERF_T6 = 32'd0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample outputs, score grants, then drive returns for this cycle
    task automatic cyc();
        logic [3:0] e;
        logic [3:0] v;
        @(posedge clk);
        #1;
        cycle++;
        if (self_rd_en != 4'd0) begin
            if (sb.size() == 0) begin
                check("unexpected_grant", 32'(self_rd_en), 32'd0);
            end else begin
                e = sb.pop_front();
                check("grant", 32'(self_rd_en), 32'(e));
            end
            if (first_gnt < 0) first_gnt = cycle;
            last_gnt = cycle;
        end
        if (ret_mode == 1) begin
            ldq_data_valid = d2;
            ldq_data_ready = d2;
            if (d2 != 4'd0) last_ret = cycle;
            d2 = d1;
            d1 = self_rd_en;
        end else if (ret_mode == 2) begin
            v = self_rd_en & ret_mask;
            ldq_data_valid = v;
            ldq_data_ready = v;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_init"}, 32'(init), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_rd_en"}, 32'(self_rd_en), 32'd0);
        check({tag, "_wr_en"}, 32'(self_wr_en), 32'd0);
        check({tag, "_perf"}, perf_cycles, 32'd0);
    endtask

    task automatic push_rr(input int rounds);
        logic [3:0] g;
        for (int r = 0; r < rounds; r++) begin
            for (int q = 0; q < 4; q++) begin
                g = 4'd1 << q;
                sb.push_back(g);
            end
        end
    endtask

    initial begin
        int k;
        int fires;
        int fire_cycle;
        int init_cycle;
        logic rdy;

        rstn = 1'b0; enable = 1'b1; mode = 1'b0;
        cfg_num_ld = 16'd3; cfg_num_st = 16'd0;
        ldq_data_valid = '0; ldq_data_ready = '0;
        stq_valid = '0; stq_ready = '0;
        ret_mode = 0; ret_mask = '0; d1 = '0; d2 = '0;
        first_gnt = -1; last_gnt = -1; last_ret = -1;

        // T1: reset held with enable high
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("t1_reset");
        rstn = 1'b1;
        cyc();
        check("t1_init_pulse", 32'(init), 32'd1);
        check("t1_busy_init", 32'(busy), 32'd1);

        // T2: round-robin, 3 loads/queue, data back 2 cycles after each grant
        push_rr(3);
        ret_mode = 1;
        cyc();
        check("t2_init_drop", 32'(init), 32'd0);
        k = 0;
        while (!done && k < 60) begin
            cyc();
            k++;
        end
        check("t2_done", 32'(done), 32'd1);
        check("t2_sb_empty", 32'(sb.size()), 32'd0);
        check("t2_grant_span", 32'(last_gnt - first_gnt), 32'd11);
        check("t2_last_ret", 32'(last_ret - last_gnt), 32'd2);
        check("t2_done_lat", 32'(cycle - last_ret), 32'd2);
        ret_mode = 0; ldq_data_valid = '0; ldq_data_ready = '0;
        cyc();
        check("t2_done_held", 32'(done), 32'd1);
        check("t2_busy_done", 32'(busy), 32'd0);
        enable = 1'b0;
        cyc();
        check("t2_done_clear", 32'(done), 32'd0);

        // T3: parallel grants, 10 loads/queue, credits cap at 8
        mode = 1'b1; cfg_num_ld = 16'd10;
        first_gnt = -1; last_gnt = -1;
        enable = 1'b1;
        cyc();
        check("t3_init", 32'(init), 32'd1);
        init_cycle = cycle;
        for (int i = 0; i < 8; i++) sb.push_back(4'hF);
        for (int i = 0; i < 12; i++) cyc();
        check("t3_sb_empty", 32'(sb.size()), 32'd0);
        check("t3_first_gnt", 32'(first_gnt - init_cycle), 32'd1);
        check("t3_gnt_span", 32'(last_gnt - first_gnt), 32'd7);
        check("t3_busy_stall", 32'(busy), 32'd1);
        ldq_data_valid = 4'b0100; ldq_data_ready = 4'b0100;
        sb.push_back(4'b0100);
        cyc();
        ldq_data_valid = '0; ldq_data_ready = '0;
        check("t3_q2_regrant", 32'(self_rd_en), 32'h4);
        for (int i = 0; i < 4; i++) cyc();
        check("t3_sb_empty2", 32'(sb.size()), 32'd0);
        // Mid-job reset drops everything immediately
        rstn = 1'b0;
        #1;
        check_idle_outputs("t3_reset");
        enable = 1'b0; mode = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // T4: 5 stores with toggling ready, no loads
        cfg_num_ld = 16'd0; cfg_num_st = 16'd5;
        enable = 1'b1;
        cyc();
        check("t4_init", 32'(init), 32'd1);
        fires = 0; fire_cycle = -1; rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (fire_cycle >= 0 && cycle == fire_cycle + 1) begin
                check("t4_wr_drop", 32'(self_wr_en), 32'd0);
                check("t4_done_wait", 32'(done), 32'd0);
            end else if (fire_cycle >= 0 && cycle == fire_cycle + 2) begin
                break;
            end else begin
                check("t4_wr_active", 32'(self_wr_en), 32'd1);
            end
            stq_valid = self_wr_en;
            stq_ready = rdy;
            if ((self_wr_en & rdy) != 1'b0) begin
                fires++;
                if (fires == 5) fire_cycle = cycle;
            end
            rdy = ~rdy;
        end
        stq_valid = '0; stq_ready = '0;
        check("t4_fires", 32'(fires), 32'd5);
        check("t4_done", 32'(done), 32'd1);
        enable = 1'b0;
        cyc();
        check("t4_done_clear", 32'(done), 32'd0);

        // T5: abort with 3 credits outstanding on q1 only
        cfg_num_ld = 16'd3; cfg_num_st = 16'd0; mode = 1'b0;
        first_gnt = -1; last_gnt = -1;
        ret_mode = 2; ret_mask = 4'b1101;
        enable = 1'b1;
        cyc();
        push_rr(3);
        for (int i = 0; i < 13; i++) cyc();
        check("t5_sb_empty", 32'(sb.size()), 32'd0);
        check("t5_gnt_span", 32'(last_gnt - first_gnt), 32'd11);
        check("t5_run_not_done", 32'(done), 32'd0);
        ret_mode = 0; ldq_data_valid = '0; ldq_data_ready = '0;
        enable = 1'b0;
        cyc();
        check("t5_drain_busy", 32'(busy), 32'd1);
        for (int r = 0; r < 3; r++) begin
            ldq_data_valid = 4'b0010; ldq_data_ready = 4'b0010;
            cyc();
            ldq_data_valid = '0; ldq_data_ready = '0;
            check("t5_drain_busy_r", 32'(busy), 32'd1);
            check("t5_drain_done", 32'(done), 32'd0);
            if (r < 2) cyc();
        end
        cyc();
        check("t5_idle_busy", 32'(busy), 32'd0);
        check("t5_idle_done", 32'(done), 32'd0);

        // T6: all-zero job completes after a single RUN cycle
        cfg_num_ld = 16'd0; cfg_num_st = 16'd0;
        enable = 1'b1;
        cyc();
        check("t6_init", 32'(init), 32'd1);
        cyc();
        check("t6_run_busy", 32'(busy), 32'd1);
        check("t6_run_done", 32'(done), 32'd0);
        cyc();
        check("t6_done", 32'(done), 32'd1);
        check("t6_perf", perf_cycles, PERF_T6);
        enable = 1'b0;
        cyc();
        check("t6_done_clear", 32'(done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
